seq_square_root: RTL



---
 rtl/seq_square_root_pkg.sv | 19 +
 rtl/seq_square_root_step.sv | 24 ++
 rtl/seq_square_root.sv | 97 +++++++++
 3 files changed

// File: rtl/seq_square_root_pkg.sv
// Shared types and helpers for the sequential fixed-point square root.
// Holds the FSM state type, rounding-mode constants and result-width helper.
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sqrt_state_t;

    localparam int RND_FLOOR   = 0;
    localparam int RND_NEAREST = 1;

    // Integer part of the root needs ceil(in_w/2) bits.
    function automatic int sqrt_out_w(input int in_w, input int frac_w);
        return (in_w + 1) / 2 + frac_w;
    endfunction

endpackage

// File: rtl/seq_square_root_step.sv
// One digit of the remainder-based square root: brings in two radicand bits
// and decides the next result bit. Purely combinational.
module sqrt_step #(
    parameter int OUT_W = 12
) (
    input  logic [OUT_W+1:0] rem,
    input  logic [OUT_W-1:0] y,
    input  logic [1:0]       bits,
    output logic [OUT_W+1:0] rem_next,
    output logic [OUT_W-1:0] y_next
);

    logic [OUT_W+1:0] rem_sh;
    logic [OUT_W+1:0] trial;
    logic             ge;

    // The dropped top bits of rem are always zero: rem never exceeds 2*y.
    assign rem_sh   = (rem << 2) | {{OUT_W{1'b0}}, bits};
    assign trial    = {y, 2'b01};
    assign ge       = (rem_sh >= trial);
    assign rem_next = ge ? (rem_sh - trial) : rem_sh;
    assign y_next   = (y << 1) | {{(OUT_W-1){1'b0}}, ge};

endmodule

// File: rtl/seq_square_root.sv
// Sequential multiplier-free square root: one result bit per clock,
// returning floor or round-to-nearest of sqrt(in) * 2^FRAC_W.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | iterating, one result bit per cycle
// DONE  | single-cycle result-valid pulse; start here is accepted
module seq_square_root
    import sqrt_pkg::*;
#(
    parameter  int IN_W          = 8,
    parameter  int FRAC_W        = 8,
    parameter  int ROUND_NEAREST = RND_FLOOR,
    localparam int OUT_W         = sqrt_out_w(IN_W, FRAC_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IN_W-1:0]  in,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] out,
    output logic             exact
);

    localparam int R_W   = 2 * OUT_W;
    localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    sqrt_state_t      state;
    logic [R_W-1:0]   rad;
    logic [R_W-1:0]   rad_init;
    logic [OUT_W+1:0] rem;
    logic [OUT_W+1:0] rem_next;
    logic [OUT_W-1:0] y;
    logic [OUT_W-1:0] y_next;
    logic [OUT_W-1:0] y_round;
    logic [CNT_W-1:0] cnt;

    assign rad_init = R_W'(in) << (2 * FRAC_W);

    sqrt_step #(.OUT_W(OUT_W)) u_step (
        .rem      (rem),
        .y        (y),
        .bits     (rad[R_W-1 -: 2]),
        .rem_next (rem_next),
        .y_next   (y_next)
    );

    // Round half-up when the remainder exceeds y; never wrap past all-ones.
    always_comb begin
        y_round = y_next;
        if (ROUND_NEAREST == RND_NEAREST && {2'b00, y_next} < rem_next && y_next != '1)
            y_round = y_next + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rad   <= '0;
            rem   <= '0;
            y     <= '0;
            cnt   <= '0;
            out   <= '0;
            exact <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= CALC;
                        rad   <= rad_init;
                        rem   <= '0;
                        y     <= '0;
                        cnt   <= CNT_W'(OUT_W - 1);
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    rad <= rad << 2;
                    rem <= rem_next;
                    y   <= y_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= DONE;
                        out   <= y_round;
                        exact <= (rem_next == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule
